exe_div_ctrl: RTL and testbench
===============================

// Module: exe_div_ctrl
// PURPOSE
//  Iterative radix-2 divider sequencer beside the execute stage. Serves DIV/DIVU:
//  latches operands, stalls the pipeline for 32 iterations, then returns
//  {HI=remainder, LO=quotient} for the HI/LO write path. Single divide resource,
//  one operation in flight. The pipeline flush input cancels it.
// PARAMETERS
//  DATA_W  32  operand width; quotient and remainder are DATA_W each
//  CNT_W   6   iteration counter width; must satisfy 2**CNT_W > DATA_W
// PORTS
//  cpu_clk_50M   in   1         clock, rising edge
//  cpu_rst_n     in   1         asynchronous reset, active-low
//  div_start_i   in   1         execute stage holds a DIV/DIVU; held high while stalled
//  div_signed_i  in   1         1=DIV (two's complement), 0=DIVU; sampled with start
//  div_opa_i     in   DATA_W    dividend (rs)
//  div_opb_i     in   DATA_W    divisor (rt)
//  flush_i       in   1         cancel any operation in progress
//  stall_req_o   out  1         stall request to the pipeline controller
//  div_ready_o   out  1         1-cycle pulse: div_hilo_o valid and written this cycle
//  div_busy_o    out  1         FSM not in IDLE
//  div_hilo_o    out  2*DATA_W  {remainder, quotient}; registered
// BEHAVIOUR
//  Reset (async, low): FSM=IDLE, counter=0; stall_req_o=0, div_ready_o=0,
//   div_busy_o=0, div_hilo_o=0. Reset mid-operation discards the operation.
//  States: IDLE, DIVZ, ON, END.
//  - IDLE: start & !flush -> latch sign flag, |opa|, |opb| (absolute values only when
//    signed), sign(opa), and sign(opa)^sign(opb). Next state is DIVZ if opb==0 and the
//    macro is defined, otherwise ON. Counter=0.
//  - ON: one restoring step per cycle on a 2*DATA_W+1 shift register. Shift left, trial
//    subtract the divisor from the upper half, keep the result if non-negative, set
//    quotient bit. After DATA_W steps (counter==DATA_W-1) go to END.
//  - END: apply the sign fix. Quotient is negated if the operand signs differ.
//    Remainder takes the sign of the dividend. Register the result into div_hilo_o.
//    Pulse div_ready_o, then go to IDLE.
//  - DIVZ: go to END with hi=opa (raw), lo={DATA_W{1'b1}}; no sign fix.
//  stall_req_o: combinational. Equals (IDLE & start & !flush) | DIVZ | ON.
//   Low in END, so the pipeline advances on the END cycle and start drops.
//  Latency: start seen in IDLE at cycle t. ON runs t+1..t+32. END and ready occur at
//   t+33. Total stall is 33 cycles.
//  div_hilo_o holds the last result until the next END. It does not change on a cancel.
//  div_start_i is ignored outside IDLE. Operands are not re-sampled while busy.
//  flush_i in any state: next state IDLE, no ready pulse, stall_req_o low in the same
//   cycle. flush_i together with start in IDLE: no operation starts.
//  Width rules: 0x80000000 / -1 (signed) gives quotient 0x80000000 and remainder 0.
//   The negation wraps and no exception is raised.
//  Back-to-back: a new start in the IDLE cycle right after END begins a new operation.
// CONFIGURATION
//  DIV_ZERO_FAST_EN defined: divisor==0 takes IDLE->DIVZ->END. Ready arrives 2 cycles
//   after start, with hi=opa and lo=0xFFFFFFFF, for both signed and unsigned divides.
//  Not defined: divisor==0 runs the full 32-cycle path. DIVU gives hi=opa,
//   lo=0xFFFFFFFF. The signed result is architecturally UNPREDICTABLE and not checked.
// TESTING
//  1 DIVU 100/7 -> stall 33 cycles; ready at t+33; hilo={32'd2, 32'd14}.
//  2 DIV -7/2 -> hilo={32'hFFFFFFFF, 32'hFFFFFFFD}; DIV 7/-2 -> {32'd1, 32'hFFFFFFFD}.
//  3 DIV 0x80000000/0xFFFFFFFF -> hilo={32'h0, 32'h80000000}; DIVU same operands
//    -> {32'h80000000, 32'h0}.
//  4 flush_i at t+10 -> stall low that cycle, IDLE next, no ready, hilo unchanged. Next
//    DIVU 9/3 -> {0, 3}.
//  5 DIVU 5/0 -> with DIV_ZERO_FAST_EN, ready at t+2 with {5, 0xFFFFFFFF}. Without it,
//    ready at t+33 with the same value.
//  6 cpu_rst_n low at t+15 -> all outputs 0 immediately; start held after reset
//    release begins a fresh 33-cycle operation.

Source files
------------

// File: rtl/exe_div_ctrl.sv
// Iterative radix-2 restoring divider sequencer for DIV/DIVU, returning {remainder, quotient}.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iteration loop via the DIVZ state.
module exe_div_ctrl #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  cpu_clk_50M,
  input  logic                  cpu_rst_n,
  input  logic                  div_start_i,
  input  logic                  div_signed_i,
  input  logic [DATA_W-1:0]     div_opa_i,
  input  logic [DATA_W-1:0]     div_opb_i,
  input  logic                  flush_i,
  output logic                  stall_req_o,
  output logic                  div_ready_o,
  output logic                  div_busy_o,
  output logic [2*DATA_W-1:0]   div_hilo_o
);

`ifdef DIV_ZERO_FAST_EN
  localparam bit FAST_Z = 1'b1;
`else
  localparam bit FAST_Z = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, DIVZ, ON, END} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic                  neg_q, neg_r;
  logic [DATA_W-1:0]     dvsr;
  logic [2*DATA_W-1:0]   acc;
  logic [2*DATA_W-1:0]   hilo;
  logic                  accept, zero_fast, last, stall;

  logic [2*DATA_W:0]     shifted;
  logic [DATA_W:0]       upper;
  logic [DATA_W-1:0]     diff;
  logic                  ge;
  logic [2*DATA_W-1:0]   acc_step;
  logic [2*DATA_W-1:0]   res_on;

  function automatic logic [DATA_W-1:0] abs_val(input logic signed [DATA_W-1:0] v);
    return v[DATA_W-1] ? DATA_W'(-v) : DATA_W'(v);
  endfunction

  // Two's complement negate; wraps for the most negative value.
  function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v, input logic n);
    return n ? (~v + DATA_W'(1)) : v;
  endfunction

  assign accept    = (state == IDLE) && div_start_i && !flush_i;
  assign zero_fast = FAST_Z && (div_opb_i == '0);
  assign last      = (cnt == CNT_W'(DATA_W - 1));

  // One restoring step on the widened {remainder, quotient} shift register
  always_comb begin
    shifted  = {1'b0, acc, 1'b0};
    upper    = shifted[2*DATA_W:DATA_W];
    ge       = (upper >= {1'b0, dvsr});
    diff     = upper[DATA_W-1:0] - dvsr;
    acc_step = ge ? {diff, shifted[DATA_W-1:1], 1'b1} : shifted[2*DATA_W-1:0];
    res_on   = {neg_if(acc_step[2*DATA_W-1:DATA_W], neg_r),
                neg_if(acc_step[DATA_W-1:0], neg_q)};
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: if (accept) begin
        stall     = 1'b1;
        state_nxt = zero_fast ? DIVZ : ON;
      end
      DIVZ: begin
        stall     = 1'b1;
        state_nxt = END;
      end
      ON: begin
        stall = 1'b1;
        if (last) state_nxt = END;
      end
      END:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush_i) begin
      state_nxt = IDLE;
      stall     = 1'b0;
    end
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      hilo  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == ON) ? cnt + CNT_W'(1) : '0;
      // Result lands on entry to END so it is valid alongside the ready pulse
      if (!flush_i) begin
        if (state == ON && last)
          hilo <= res_on;
        else if (state == DIVZ)
          hilo <= {acc[DATA_W-1:0], {DATA_W{1'b1}}};
      end
    end
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (accept) begin
      neg_r <= div_signed_i & div_opa_i[DATA_W-1];
      neg_q <= div_signed_i & (div_opa_i[DATA_W-1] ^ div_opb_i[DATA_W-1]);
      dvsr  <= div_signed_i ? abs_val(div_opb_i) : div_opb_i;
      acc   <= {{DATA_W{1'b0}},
                (zero_fast || !div_signed_i) ? div_opa_i : abs_val(div_opa_i)};
    end else if (state == ON) begin
      acc <= acc_step;
    end
  end

  assign stall_req_o = stall & cpu_rst_n;
  assign div_ready_o = (state == END) && !flush_i;
  assign div_busy_o  = (state != IDLE);
  assign div_hilo_o  = hilo;

endmodule

// File: tb/tb_exe_div_ctrl.sv
// Directed scoreboard bench for exe_div_ctrl: latency, stall length, signed/unsigned results,
// flush and asynchronous reset mid-operation, zero-divisor handling (DIV_ZERO_FAST_EN aware).
module tb_exe_div_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, sgn, flush;
  logic [31:0] opa, opb;
  logic        stall, ready, busy;
  logic [63:0] hilo;

  logic [63:0] sb[$];
  logic [63:0] last_hilo;
  int          n_vec = 0;
  int          n_err = 0;
  int          stall_cnt;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = 33;
`endif

  exe_div_ctrl #(.DATA_W(32), .CNT_W(6)) dut (
    .cpu_clk_50M  (clk),
    .cpu_rst_n    (rst_n),
    .div_start_i  (start),
    .div_signed_i (sgn),
    .div_opa_i    (opa),
    .div_opb_i    (opb),
    .flush_i      (flush),
    .stall_req_o  (stall),
    .div_ready_o  (ready),
    .div_busy_o   (busy),
    .div_hilo_o   (hilo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    sgn   = s;
    opa   = a;
    opb   = b;
    stall_cnt = 0;
    #1;
    if (stall) stall_cnt = 1;
  endtask

  task automatic wait_ready(input string tag, input int exp_lat);
    int n = 0;
    bit got = 0;
    logic [63:0] e;
    while (!got && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (ready) got = 1;
      else if (stall) stall_cnt++;
    end
    check({tag, " latency"}, 64'(n), 64'(exp_lat));
    if (got) begin
      check({tag, " stall_at_end"}, 64'(stall), 64'd0);
      check({tag, " busy_at_end"}, 64'(busy), 64'd1);
      check({tag, " stall_cycles"}, 64'(stall_cnt), 64'(exp_lat));
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({tag, " hilo"}, hilo, e);
        last_hilo = e;
      end else begin
        check({tag, " scoreboard_depth"}, 64'(sb.size()), 64'd1);
      end
    end
    start = 1'b0;
  endtask

  task automatic op(input string tag, input logic s, input logic [31:0] a,
                    input logic [31:0] b, input logic [63:0] e, input int lat);
    sb.push_back(e);
    drive(s, a, b);
    wait_ready(tag, lat);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; sgn = 1'b0; flush = 1'b0; opa = '0; opb = '0;
    repeat (3) @(negedge clk);
    check("reset stall", 64'(stall), 64'd0);
    check("reset ready", 64'(ready), 64'd0);
    check("reset busy",  64'(busy),  64'd0);
    check("reset hilo",  hilo,       64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    op("divu_100_7",  1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
    op("div_m7_2",    1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
    op("div_7_m2",    1'b1, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 33);
    op("div_m100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, {32'hFFFFFFFE, 32'd14}, 33);
    op("divu_max_16", 1'b0, 32'hFFFFFFFF, 32'h10, {32'hF, 32'h0FFFFFFF}, 33);
    op("divu_minint", 1'b0, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'h0}, 33);
    op("div_minint",  1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 33);

    // Cancel at t+10: stall drops in that cycle, machine idles, result untouched
    drive(1'b0, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush stall_same_cycle", 64'(stall), 64'd0);
    check("flush no_ready", 64'(ready), 64'd0);
    @(negedge clk);
    check("flush busy_after", 64'(busy), 64'd0);
    check("flush ready_after", 64'(ready), 64'd0);
    check("flush hilo_kept", hilo, last_hilo);
    flush = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("flush idle_ready", 64'(ready), 64'd0);
    op("divu_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

    op("divu_5_0", 1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF}, ZLAT);
`ifdef DIV_ZERO_FAST_EN
    op("div_5_0",  1'b1, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF}, 2);
    op("div_m5_0", 1'b1, 32'hFFFFFFFB, 32'd0, {32'hFFFFFFFB, 32'hFFFFFFFF}, 2);
`endif

    // Asynchronous reset mid-operation, start held across release
    sb.push_back({32'd0, 32'd100});
    drive(1'b0, 32'd1000, 32'd10);
    repeat (15) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid stall", 64'(stall), 64'd0);
    check("rst_mid ready", 64'(ready), 64'd0);
    check("rst_mid busy",  64'(busy),  64'd0);
    check("rst_mid hilo",  hilo,       64'd0);
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back({32'd0, 32'd100});
    stall_cnt = 0;
    #1;
    if (stall) stall_cnt = 1;
    wait_ready("after_reset", 33);

    op("b2b_a", 1'b0, 32'd77, 32'd5, {32'd2, 32'd15}, 33);
    op("b2b_b", 1'b1, 32'hFFFFFFB3, 32'd5, {32'hFFFFFFFE, 32'hFFFFFFF1}, 33);

    check("scoreboard empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
